// File: rtl/timer_pkg.sv
// Shared constants and helpers for the 1 us tick timer.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package timer_pkg;

  // Nominal clock cycles per microsecond at 25 MHz.
  localparam int CLK_PER_US_DEFAULT = 25;

  // Counter width for a modulo-n counter, never narrower than one bit.
  function automatic int cnt_width(input int n);
    int w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/us_prescaler.sv
// Microsecond prescaler: strobes for one clock every CLK_PER_US clocks.
// Latency: strobe is combinational from the registered prescale count.
// Backpressure: none; with TIMER_PAUSE_EN, i_pause freezes the count and masks the strobe.
module us_prescaler
  import timer_pkg::*;
#(
  parameter int CLK_PER_US = CLK_PER_US_DEFAULT
) (
  input  logic i_clk_25MHz,
  input  logic i_reset,
`ifdef TIMER_PAUSE_EN
  input  logic i_pause,
`endif
  output logic o_strobe
);

  localparam int              W    = cnt_width(CLK_PER_US);
  localparam logic [W-1:0]    LAST = W'(CLK_PER_US - 1);

  if (CLK_PER_US < 1) begin : g_bad_clk_per_us
    $error("us_prescaler: CLK_PER_US must be >= 1");
  end

  // Power-up value matters on FPGA targets where reset may not be applied at once.
  logic [W-1:0] pre_cnt = '0;
  logic         run;

`ifdef TIMER_PAUSE_EN
  assign run = !i_pause;
`else
  assign run = 1'b1;
`endif

  // A paused prescaler must not advance the microsecond counter downstream.
  assign o_strobe = run && (pre_cnt == LAST);

  // Modulo-CLK_PER_US count, wrapping by equality so it never exceeds LAST.
  always_ff @(posedge i_clk_25MHz) begin
    if (i_reset) begin
      pre_cnt <= '0;
    end else if (run) begin
      pre_cnt <= (pre_cnt == LAST) ? '0 : pre_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/timer_1us_tick.sv
// Periodic tick: o_q pulses one clock every PERIOD_US*CLK_PER_US clocks (optional macro TIMER_PAUSE_EN adds i_pause).
// Latency: first pulse registered PERIOD_US*CLK_PER_US edges after the last reset edge.
// Backpressure: none; with TIMER_PAUSE_EN, i_pause holds both counters and forces o_q low.
module timer_1us_tick
  import timer_pkg::*;
#(
  parameter int PERIOD_US  = 90000,
  parameter int CLK_PER_US = CLK_PER_US_DEFAULT
) (
  input  logic i_clk_25MHz,
  input  logic i_reset,
`ifdef TIMER_PAUSE_EN
  input  logic i_pause,
`endif
  output logic o_q
);

  localparam int           W       = cnt_width(PERIOD_US);
  localparam logic [W-1:0] US_LAST = W'(PERIOD_US - 1);

  if (PERIOD_US < 1 || CLK_PER_US < 1) begin : g_bad_params
    $error("timer_1us_tick: PERIOD_US and CLK_PER_US must be >= 1");
  end

  logic         us_strobe;
  // Power-up values matter on FPGA targets where reset may not be applied at once.
  logic [W-1:0] us_cnt = '0;
  logic         q_r    = 1'b0;

  us_prescaler #(
    .CLK_PER_US (CLK_PER_US)
  ) u_pre (
    .i_clk_25MHz (i_clk_25MHz),
    .i_reset     (i_reset),
`ifdef TIMER_PAUSE_EN
    .i_pause     (i_pause),
`endif
    .o_strobe    (us_strobe)
  );

  // Count microseconds modulo PERIOD_US and register the tick on the terminal strobe.
  // The prescaler masks its strobe during pause, so o_q drops and us_cnt holds for free.
  always_ff @(posedge i_clk_25MHz) begin
    if (i_reset) begin
      us_cnt <= '0;
      q_r    <= 1'b0;
    end else begin
      if (us_strobe) begin
        us_cnt <= (us_cnt == US_LAST) ? '0 : us_cnt + 1'b1;
      end
      q_r <= us_strobe && (us_cnt == US_LAST);
    end
  end

  assign o_q = q_r;

endmodule

// File: tb/tb_timer_1us_tick.sv
// Directed bench for timer_1us_tick: three instances with different parameter sets.
// Latency: n/a.
// Backpressure: n/a.
module tb_timer_1us_tick;

  logic clk   = 1'b0;
  logic rst_a = 1'b1;
  logic rst_b = 1'b1;
  logic rst_c = 1'b1;
  logic q_a, q_b, q_c;
`ifdef TIMER_PAUSE_EN
  logic pause = 1'b0;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #20 clk = ~clk;

  // PERIOD_US=4, CLK_PER_US=3 -> period 12 clocks
  timer_1us_tick #(4, 3) dut_a (
    .i_clk_25MHz (clk),
    .i_reset     (rst_a),
`ifdef TIMER_PAUSE_EN
    .i_pause     (pause),
`endif
    .o_q         (q_a)
  );

  // Degenerate: both parameters 1
  timer_1us_tick #(1, 1) dut_b (
    .i_clk_25MHz (clk),
    .i_reset     (rst_b),
`ifdef TIMER_PAUSE_EN
    .i_pause     (pause),
`endif
    .o_q         (q_b)
  );

  // Default CLK_PER_US (25), 1 ms period -> 25000 clocks
  timer_1us_tick #(.PERIOD_US(1000)) dut_c (
    .i_clk_25MHz (clk),
    .i_reset     (rst_c),
`ifdef TIMER_PAUSE_EN
    .i_pause     (pause),
`endif
    .o_q         (q_c)
  );

  // Single reset edge on dut_a; returns at the negedge right after that edge (E0).
  task automatic reset_a();
    @(negedge clk);
    rst_a = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst_a = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_a = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      @(negedge clk);
      n_checks++;
      if (q_a !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_hold cycle %0d: o_q=%b expected 0", i, q_a);
      end
    end
    rst_a = 1'b0;
    n_checks++;
    if (dut_a.u_pre.pre_cnt !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_pre_cnt: got %0d expected 0", dut_a.u_pre.pre_cnt);
    end
    n_checks++;
    if (dut_a.us_cnt !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_us_cnt: got %0d expected 0", dut_a.us_cnt);
    end
  endtask

  task automatic test_period();
    logic exp;
    reset_a();
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      @(negedge clk);
      exp = (k == 12 || k == 24 || k == 36);
      n_checks++;
      if (q_a !== exp) begin
        n_fail++;
        $display("FAIL period edge %0d: o_q=%b expected %b", k, q_a, exp);
      end
    end
  endtask

  task automatic test_mid_reset();
    logic exp;
    reset_a();
    for (int k = 1; k <= 6; k++) begin
      @(posedge clk);
      @(negedge clk);
    end
    rst_a = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst_a = 1'b0;
    n_checks++;
    if (q_a !== 1'b0 || dut_a.us_cnt !== 2'd0 || dut_a.u_pre.pre_cnt !== 2'd0) begin
      n_fail++;
      $display("FAIL mid_reset_clear: o_q=%b us_cnt=%0d pre_cnt=%0d expected all 0",
               q_a, dut_a.us_cnt, dut_a.u_pre.pre_cnt);
    end
    for (int k = 1; k <= 14; k++) begin
      @(posedge clk);
      @(negedge clk);
      exp = (k == 12);
      n_checks++;
      if (q_a !== exp) begin
        n_fail++;
        $display("FAIL mid_reset edge %0d after reset: o_q=%b expected %b", k, q_a, exp);
      end
    end
  endtask

  task automatic test_unit_params();
    @(negedge clk);
    rst_b = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst_b = 1'b0;
    n_checks++;
    if (q_b !== 1'b0) begin
      n_fail++;
      $display("FAIL unit_reset: o_q=%b expected 0", q_b);
    end
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk);
      @(negedge clk);
      n_checks++;
      if (q_b !== 1'b1) begin
        n_fail++;
        $display("FAIL unit edge %0d: o_q=%b expected 1", k, q_b);
      end
    end
  endtask

  task automatic test_long_period();
    logic exp;
    @(negedge clk);
    rst_c = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst_c = 1'b0;
    for (int k = 1; k <= 25001; k++) begin
      @(posedge clk);
      @(negedge clk);
      exp = (k == 25000);
      n_checks++;
      if (q_c !== exp) begin
        n_fail++;
        $display("FAIL long_period edge %0d: o_q=%b expected %b", k, q_c, exp);
      end
    end
  endtask

`ifdef TIMER_PAUSE_EN
  task automatic test_pause();
    logic exp;
    reset_a();
    for (int k = 1; k <= 30; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (k == 6)  pause = 1'b1;
      if (k == 11) pause = 1'b0;
      exp = (k == 17 || k == 29);
      n_checks++;
      if (q_a !== exp) begin
        n_fail++;
        $display("FAIL pause edge %0d: o_q=%b expected %b", k, q_a, exp);
      end
    end
  endtask
`endif

  initial begin
    repeat (3) @(posedge clk);
    test_reset();
    test_period();
    test_mid_reset();
`ifdef TIMER_PAUSE_EN
    test_pause();
`endif
    test_unit_params();
    test_long_period();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
